// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// A grant lasts up to MAXBURST words; the FIFO's registered full flag stalls the burst.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wren,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IdW-1:0]  last_id_q, last_id_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;

  logic            owner_valid;
  logic            owner_last;
  logic            xfer;
  logic            burst_done;
  logic            release_c;
  logic            arb;
  logic            found;
  logic [IdW-1:0]  next_id;

  // While granted, last_id_q is the current owner's index.
  assign owner_valid = req_valid[last_id_q];
  assign owner_last  = req_last[last_id_q];
  assign xfer        = (state_q == StGrant) && owner_valid && !fifo_full;
  assign burst_done  = (({1'b0, burst_cnt_q} + 9'd1) == 9'(MAXBURST));
  assign release_c   = (state_q == StGrant) &&
                       (!owner_valid || (xfer && (owner_last || burst_done)));
  assign arb         = (state_q == StIdle) || release_c;

  // Scan last_id+1 .. last_id+NREQ modulo NREQ; the previous owner comes last.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found   = 1'b0;
    next_id = last_id_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last_id_q) + k) % NREQ;
      if (!found && req_valid[IdW'(idx)]) begin
        found   = 1'b1;
        next_id = IdW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_id_q   <= IdW'(NREQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    if (arb) begin
      burst_cnt_d = '0;
      if (found) begin
        state_d   = StGrant;
        grant_d   = NREQ'(1) << next_id;
        last_id_d = next_id;
      end else begin
        state_d = StIdle;
        grant_d = '0;
      end
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end
  end

  always_comb begin
    req_ready = grant_q & {NREQ{~fifo_full}};
    fifo_wren = xfer;
    fifo_din  = '0;
    if (state_q == StGrant) begin
      fifo_din = req_data[int'(last_id_q) * DWIDTH +: DWIDTH];
    end
    grant = grant_q;
    busy  = (state_q == StGrant);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one FIFO among `NREQ` requesters in the FIFO's write-clock domain. Each requester presents words over a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to `MAXBURST` words and drives the FIFO `wren`/`din` pair. It honours the FIFO's registered `full` flag, so no word is lost or duplicated under backpressure.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 8: data width; must match the FIFO `DWIDTH`.
- `MAXBURST`, 4: maximum words per grant, 1..255.

- `clk`  in  1  write-side clock, the same clock as the FIFO `wclk`.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i has a word.
- `req_last`  in  NREQ  bit i: the word presented by requester i ends its burst.
- `req_data`  in  NREQ*DWIDTH  requester i word occupies bits [i*DWIDTH +: DWIDTH].
- `req_ready`  out  NREQ  bit i: the word from requester i is accepted this cycle if valid.
- `fifo_full`  in  1  FIFO `full`, registered in the FIFO.
- `fifo_wren`  out  1  FIFO write enable.
- `fifo_din`  out  DWIDTH  FIFO write data.
- `grant`  out  NREQ  one-hot current owner, or all zero.
- `busy`  out  1  a grant is held.

## Operation
- **States.**
  - IDLE: `grant`=0.
  - GRANT: exactly one `grant` bit is set.
- **Priority pointer.** `last_id` is log2(NREQ) bits wide and holds the index of the most recent owner.
  - Reset value is NREQ-1, so requester 0 has first priority.
- **Arbitration event.** Occurs on any clock edge where the state is IDLE or the release condition is true.
  - The new owner is the first i with `req_valid[i]`=1, scanning `last_id`+1, `last_id`+2, ... modulo NREQ, with `last_id` itself last.
  - If an owner is found: state→GRANT, `grant`←onehot(i), `last_id`←i, `burst_cnt`←0.
  - Otherwise: state→IDLE.
- **Transfer.** A transfer occurs in a cycle where state=GRANT, `req_valid[g]`=1 and `fifo_full`=0, where g is the granted index.
- **Combinational outputs.**
  - `req_ready[i]` = `grant[i]` & ~`fifo_full`.
  - `fifo_wren` = transfer.
  - `fifo_din` = `req_data` slice g; it is 0 when `grant`=0.
- **Burst counting.** `burst_cnt` is an 8-bit counter and increments on each transfer.
- **Release condition** (GRANT only) is any of:
  - a transfer with `req_last[g]`=1;
  - a transfer with `burst_cnt`+1 == MAXBURST;
  - `req_valid[g]`=0, meaning the owner withdrew. The arbiter releases immediately and no transfer occurs.
- **Full.** `fifo_full`=1 stalls the burst: grant is held, `burst_cnt` is unchanged, there is no release and `fifo_wren`=0.
- **Requester rule.** Once `req_valid[i]` rises, it and `req_data`/`req_last` stay stable until accepted. The arbiter does not check this; a breach counts as withdrawal.
- **Re-grant.** The sole valid requester may be re-granted on its own release edge.

## Timing
- Reset (asynchronous assert, synchronous deassert supplied externally) gives: state IDLE, `grant`=0, `busy`=0, `burst_cnt`=0, `last_id`=NREQ-1.
  - This makes `req_ready`=0, `fifo_wren`=0 and `fifo_din`=0.
- Reset mid-burst aborts the burst at once. Words already written stay in the FIFO; there is no partial-word effect.
- Request-to-grant latency: `req_valid` sampled high at edge k in IDLE gives `grant` from edge k, and the first transfer is possible in the cycle after edge k.
- Back-to-back bursts have zero bubble. The release edge is also the arbitration edge, and the new owner can transfer in the next cycle.
- Data path latency is 0: `fifo_din`/`fifo_wren` are combinational from the request inputs during the grant.
- `fifo_full` rises in the cycle after the filling write. `fifo_wren` is therefore never asserted while `fifo_full`=1, and exactly one write occurs per accepted handshake.
- `busy` = (state==GRANT), registered.

## Test plan
- **Single requester, long burst.** NREQ=4, MAXBURST=4. Requester 0 holds valid with 6 words, `last` on word 6, FIFO never full. Required: `grant`=0001 continuously, 6 consecutive `fifo_wren` pulses, a release after word 4 with an immediate re-grant to 0 and no gap, release after word 6, then IDLE.
- **Round-robin fairness.** All 4 requesters valid continuously, `req_last` tied high. Required: the grant sequence after reset is 0,1,2,3,0,1,..., with one word per grant and `fifo_wren` high every cycle after the first grant.
- **Full stall.** Requester 2 mid-burst with `burst_cnt`=2; `fifo_full` is held high for 5 cycles. Required: `fifo_wren`=0 and `req_ready`=0 for those 5 cycles, `grant` stays 0100, and the burst resumes and releases after 2 more words.
- **Owner withdraws.** Requester 1 granted drops `req_valid` with requester 3 valid. Required: no write that cycle and `grant`=1000 from the next edge.
- **Reset mid-burst.** `rstn` is pulsed low during a transfer. Required: `grant`=0, `fifo_wren`=0 and `busy`=0 immediately. After release, requesters 0 and 3 both valid gives a grant to requester 0 first.
